mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/miniRV_defs.sv | 25 ++
 rtl/mem_access_stage_if.sv | 29 ++
 rtl/mem_wb_latch.sv | 48 ++++
 rtl/mem_access_stage.sv | 119 +++++++++++
 tb/tb_mem_access_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/miniRV_defs.sv
// Shared definitions for the MEM stage: write-back select codes, wait-counter sizing,
// FSM states and the access-needed decode.
package miniRV_defs;

   typedef enum logic [1:0] {
      WselAluC = 2'd0,
      WselLoad = 2'd1,
      WselPc4  = 2'd2,
      WselExt  = 2'd3
   } wsel_e;

   localparam int unsigned WaitCntW = 8;
   localparam logic [WaitCntW-1:0] WaitTimeout = WaitCntW'(255);

   typedef enum logic {
      StIdle,
      StWait
   } mem_state_e;

   // A store, or a load (write-back of load data), needs the data bus.
   function automatic logic access_needed(input logic ram_we, input logic [1:0] wsel);
      return ram_we | (wsel == WselLoad);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus port of the MEM stage: single outstanding request held until bus_ack.
interface mem_access_stage_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_wdata,
      input  bus_rdata,
      input  bus_ack
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_wdata,
      output bus_rdata,
      output bus_ack
   );

endinterface

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register. A stall inserts a bubble (write enable dropped) while the
// data and destination hold their last values. Writes to x0 are suppressed here.
module mem_wb_latch (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic [31:0] wd_i,
   input  logic [4:0]  wr_i,
   input  logic        rf_we_i,
   output logic [31:0] wd_o,
   output logic [4:0]  wr_o,
   output logic        rf_we_o
);

   logic [31:0] wd_q, wd_d;
   logic [4:0]  wr_q, wr_d;
   logic        rf_we_q, rf_we_d;

   // Next state: bubble on stall, otherwise capture the MEM-stage result.
   always_comb begin
      wd_d    = wd_q;
      wr_d    = wr_q;
      rf_we_d = 1'b0;
      if (!stall_i) begin
         wd_d    = wd_i;
         wr_d    = wr_i;
         rf_we_d = rf_we_i && (wr_i != 5'd0);
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wd_q    <= '0;
         wr_q    <= '0;
         rf_we_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         wr_q    <= wr_d;
         rf_we_q <= rf_we_d;
      end
   end

   assign wd_o    = wd_q;
   assign wr_o    = wr_q;
   assign rf_we_o = rf_we_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-bus accesses, stalls the pipeline until the bus
// acknowledges (or a wait-counter timeout fires), and feeds the MEM/WB register.
module mem_access_stage
   import miniRV_defs::*;
(
   input  logic                      cpu_clk,
   input  logic                      cpu_rst,
   input  logic [31:0]               ALU_C_MEM_in,
   input  logic [31:0]               rD2_MEM_in,
   input  logic [31:0]               ext_MEM_in,
   input  logic [31:0]               pc4_MEM_in,
   input  logic [4:0]                wR_MEM_in,
   input  logic                      rf_we_MEM_in,
   input  logic                      ram_we_MEM_in,
   input  logic [1:0]                rf_wsel_MEM_in,
   mem_access_stage_if.master        bus,
   output logic                      mem_stall,
   output logic [31:0]               wD_MEM_fwd,
   output logic [31:0]               wD_WB_in,
   output logic [4:0]                wR_WB_in,
   output logic                      rf_we_WB_in,
   output logic                      bus_err
);

   mem_state_e          state_q, state_d;
   logic [WaitCntW-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                need;
   logic                req;
   logic                timeout;
   logic                complete;
   logic [31:0]         load_data;

   assign need = access_needed(ram_we_MEM_in, rf_wsel_MEM_in);

   // FSM next state, wait counter, sticky error and bus request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      req     = 1'b0;
      timeout = 1'b0;
      case (state_q)
         StIdle: begin
            req = need;
            if (need && !bus.bus_ack) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            req = 1'b1;
            // Ack in the final wait cycle still wins over the timeout.
            timeout = (cnt_q == WaitTimeout) && !bus.bus_ack;
            if (bus.bus_ack || timeout) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (timeout) begin
         err_d = 1'b1;
      end
      // EX/MEM may still show an access while reset is high; never request then.
      if (cpu_rst) begin
         req = 1'b0;
      end
   end

   // FSM, counter and error flag registers.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign complete  = req && (bus.bus_ack || timeout);
   assign mem_stall = need && !complete;
   assign load_data = (req && bus.bus_ack) ? bus.bus_rdata : 32'h0;

   // Write-back value selection, also used for forwarding.
   always_comb begin
      wD_MEM_fwd = ALU_C_MEM_in;
      case (rf_wsel_MEM_in)
         WselAluC: wD_MEM_fwd = ALU_C_MEM_in;
         WselLoad: wD_MEM_fwd = load_data;
         WselPc4:  wD_MEM_fwd = pc4_MEM_in;
         WselExt:  wD_MEM_fwd = ext_MEM_in;
         default:  wD_MEM_fwd = ALU_C_MEM_in;
      endcase
   end

   assign bus.bus_req   = req;
   assign bus.bus_we    = ram_we_MEM_in;
   assign bus.bus_addr  = ALU_C_MEM_in;
   assign bus.bus_wdata = rD2_MEM_in;
   assign bus_err       = err_q;

   mem_wb_latch u_mem_wb_latch (
      .clk_i   (cpu_clk),
      .rst_i   (cpu_rst),
      .stall_i (mem_stall),
      .wd_i    (wD_MEM_fwd),
      .wr_i    (wR_MEM_in),
      .rf_we_i (rf_we_MEM_in),
      .wd_o    (wD_WB_in),
      .wr_o    (wR_WB_in),
      .rf_we_o (rf_we_WB_in)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: table of single-cycle vectors, directed multi-cycle
// sequences (slow store, timeout, reset during wait) and random transactions
// against a transaction-level model.
module tb_mem_access_stage;
   import miniRV_defs::*;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [31:0] alu_c, rd2, ext, pc4;
   logic [4:0]  wr;
   logic        rf_we, ram_we;
   logic [1:0]  wsel;
   logic        mem_stall;
   logic [31:0] wd_fwd, wd_wb;
   logic [4:0]  wr_wb;
   logic        rf_we_wb, bus_err;

   int total = 0;
   int bad   = 0;

   localparam int TimeoutCycles = 256;  // completion index of an unacknowledged access

   mem_access_stage_if bus_if ();

   mem_access_stage dut (
      .cpu_clk        (cpu_clk),
      .cpu_rst        (cpu_rst),
      .ALU_C_MEM_in   (alu_c),
      .rD2_MEM_in     (rd2),
      .ext_MEM_in     (ext),
      .pc4_MEM_in     (pc4),
      .wR_MEM_in      (wr),
      .rf_we_MEM_in   (rf_we),
      .ram_we_MEM_in  (ram_we),
      .rf_wsel_MEM_in (wsel),
      .bus            (bus_if),
      .mem_stall      (mem_stall),
      .wD_MEM_fwd     (wd_fwd),
      .wD_WB_in       (wd_wb),
      .wR_WB_in       (wr_wb),
      .rf_we_WB_in    (rf_we_wb),
      .bus_err        (bus_err)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct {
      logic [31:0] alu, rd2, ext, pc4;
      logic [4:0]  wr;
      logic        rf_we, ram_we;
      logic [1:0]  wsel;
      logic [31:0] rdata;
      logic        ack;
      logic        exp_req, exp_we;
      logic [31:0] exp_fwd;
      logic        exp_rf_we_wb;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic set_insn(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                           input logic [31:0] p, input logic [4:0] w, input logic rfwe,
                           input logic rwe, input logic [1:0] ws);
      alu_c = a; rd2 = d; ext = e; pc4 = p; wr = w; rf_we = rfwe; ram_we = rwe; wsel = ws;
   endtask

   // Called at posedge+1; leaves time at the next posedge+1.
   task automatic apply_vec(input int k);
      vec_t v;
      v = vecs[k];
      set_insn(v.alu, v.rd2, v.ext, v.pc4, v.wr, v.rf_we, v.ram_we, v.wsel);
      bus_if.bus_rdata = v.rdata;
      bus_if.bus_ack   = v.ack;
      @(negedge cpu_clk);
      check($sformatf("vec%0d_req", k), bus_if.bus_req, v.exp_req);
      if (v.exp_req) begin
         check($sformatf("vec%0d_we", k), bus_if.bus_we, v.exp_we);
         check($sformatf("vec%0d_addr", k), bus_if.bus_addr, v.alu);
         check($sformatf("vec%0d_wdata", k), bus_if.bus_wdata, v.rd2);
      end
      check($sformatf("vec%0d_stall", k), mem_stall, 1'b0);
      check($sformatf("vec%0d_fwd", k), wd_fwd, v.exp_fwd);
      @(posedge cpu_clk);
      #1;
      check($sformatf("vec%0d_wd_wb", k), wd_wb, v.exp_fwd);
      check($sformatf("vec%0d_wr_wb", k), wr_wb, v.wr);
      check($sformatf("vec%0d_rf_we_wb", k), rf_we_wb, v.exp_rf_we_wb);
      bus_if.bus_ack = 1'b0;
   endtask

   initial begin : main
      int          n_stall;
      int          comp;
      int          d;
      bit          done;
      bit          req_ok;
      bit          bubble_ok;
      bit          need;
      bit          timed_out;
      bit          err_exp;
      logic [31:0] rd_ack;
      logic [31:0] load_val;
      logic [31:0] exp_fwd;

      // Vectors: {alu, rd2, ext, pc4, wr, rf_we, ram_we, wsel, rdata, ack,
      //           exp_req, exp_we, exp_fwd, exp_rf_we_wb}
      vecs[0] = '{32'h100, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 2'd1, 32'h12345678, 1'b1,
                  1'b1, 1'b0, 32'h12345678, 1'b1};
      vecs[1] = '{32'h0, 32'h0, 32'h0, 32'h44, 5'd7, 1'b1, 1'b0, 2'd2, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'h44, 1'b1};
      vecs[2] = '{32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 5'd1, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
      vecs[3] = '{32'h10, 32'h0, 32'hFFFFF800, 32'h8, 5'd31, 1'b1, 1'b0, 2'd3, 32'hBAD, 1'b1,
                  1'b0, 1'b0, 32'hFFFFF800, 1'b1};
      vecs[4] = '{32'h104, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 2'd1, 32'h0BADF00D, 1'b1,
                  1'b1, 1'b0, 32'h0BADF00D, 1'b0};
      vecs[5] = '{32'h300, 32'h11223344, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1,
                  1'b1, 1'b1, 32'h300, 1'b0};
      vecs[6] = '{32'h400, 32'h99, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1, 2'd1, 32'h5555AAAA, 1'b1,
                  1'b1, 1'b1, 32'h5555AAAA, 1'b0};
      vecs[7] = '{32'h77, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'h77, 1'b0};

      // Reset state.
      cpu_rst = 1'b1;
      set_insn('0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0);
      bus_if.bus_rdata = '0;
      bus_if.bus_ack   = 1'b0;
      @(posedge cpu_clk);
      @(posedge cpu_clk);
      #1;
      check("rst_req", bus_if.bus_req, 1'b0);
      check("rst_wd_wb", wd_wb, 32'h0);
      check("rst_wr_wb", wr_wb, 5'd0);
      check("rst_rf_we_wb", rf_we_wb, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      cpu_rst = 1'b0;

      // Single-cycle table.
      for (int k = 0; k < 8; k++) apply_vec(k);

      // Slow store: ack on the 4th request cycle, preceded by a writing ALU op.
      set_insn(32'h55, '0, '0, '0, 5'd3, 1'b1, 1'b0, 2'd0);
      @(posedge cpu_clk);
      #1;
      set_insn(32'h200, 32'hCAFEF00D, '0, '0, 5'd0, 1'b0, 1'b1, 2'd0);
      n_stall = 0;
      for (int i = 0; i < 4; i++) begin
         bus_if.bus_ack   = (i == 3);
         bus_if.bus_rdata = $urandom;
         @(negedge cpu_clk);
         check($sformatf("st_req%0d", i), bus_if.bus_req, 1'b1);
         check($sformatf("st_addr%0d", i), bus_if.bus_addr, 32'h200);
         check($sformatf("st_wdata%0d", i), bus_if.bus_wdata, 32'hCAFEF00D);
         check($sformatf("st_we%0d", i), bus_if.bus_we, 1'b1);
         if (mem_stall) n_stall++;
         @(posedge cpu_clk);
         #1;
         if (i < 3) begin
            check($sformatf("st_bubble%0d", i), rf_we_wb, 1'b0);
            check($sformatf("st_hold_wd%0d", i), wd_wb, 32'h55);
            check($sformatf("st_hold_wr%0d", i), wr_wb, 5'd3);
         end
      end
      check("st_stall_cycles", n_stall, 3);
      check("st_wd_wb", wd_wb, 32'h200);
      bus_if.bus_ack = 1'b0;
      set_insn('0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0);
      @(negedge cpu_clk);
      check("st_after_req", bus_if.bus_req, 1'b0);
      @(posedge cpu_clk);
      #1;

      // Load with no ack: times out.
      set_insn(32'h800, '0, '0, '0, 5'd4, 1'b1, 1'b0, 2'd1);
      bus_if.bus_rdata = 32'hFFFFFFFF;
      n_stall = 0;
      done    = 1'b0;
      req_ok  = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge cpu_clk);
         if (bus_if.bus_req !== 1'b1) req_ok = 1'b0;
         if (mem_stall) begin
            n_stall++;
         end else begin
            done = 1'b1;
            check("to_fwd", wd_fwd, 32'h0);
            check("to_err_before", bus_err, 1'b0);
         end
         @(posedge cpu_clk);
         #1;
      end
      check("to_done", done, 1'b1);
      check("to_req_held", req_ok, 1'b1);
      check("to_stall_cycles", n_stall, TimeoutCycles);
      check("to_bus_err", bus_err, 1'b1);
      check("to_wd_wb", wd_wb, 32'h0);
      check("to_rf_we_wb", rf_we_wb, 1'b1);
      apply_vec(0);
      check("to_err_sticky", bus_err, 1'b1);

      // Reset in the middle of a waiting load.
      set_insn(32'h900, '0, '0, '0, 5'd6, 1'b1, 1'b0, 2'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge cpu_clk);
         check($sformatf("rw_stall%0d", i), mem_stall, 1'b1);
         @(posedge cpu_clk);
         #1;
      end
      cpu_rst = 1'b1;
      #1;
      check("rw_req", bus_if.bus_req, 1'b0);
      check("rw_rf_we_wb", rf_we_wb, 1'b0);
      check("rw_bus_err", bus_err, 1'b0);
      check("rw_wd_wb", wd_wb, 32'h0);
      set_insn('0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      @(posedge cpu_clk);
      #1;
      apply_vec(1);
      apply_vec(0);

      // Random transactions against a transaction-level model.
      err_exp = 1'b0;
      for (int t = 0; t < 40; t++) begin
         set_insn($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
         d         = ($urandom_range(0, 14) == 0) ? 400 : $urandom_range(0, 4);
         need      = ram_we || (wsel == 2'd1);
         comp      = need ? ((d < TimeoutCycles) ? d : TimeoutCycles) : 0;
         timed_out = need && (d > TimeoutCycles);
         rd_ack    = $urandom;
         load_val  = timed_out ? 32'h0 : rd_ack;
         case (wsel)
            2'd0:    exp_fwd = alu_c;
            2'd1:    exp_fwd = load_val;
            2'd2:    exp_fwd = pc4;
            default: exp_fwd = ext;
         endcase
         n_stall   = 0;
         req_ok    = 1'b1;
         bubble_ok = 1'b1;
         for (int i = 0; i <= comp; i++) begin
            bus_if.bus_ack   = need ? (i == d) : 1'($urandom);
            bus_if.bus_rdata = (i == d) ? rd_ack : $urandom;
            @(negedge cpu_clk);
            if (bus_if.bus_req !== need) req_ok = 1'b0;
            if (mem_stall) n_stall++;
            if (i == comp) check($sformatf("rnd%0d_fwd", t), wd_fwd, exp_fwd);
            @(posedge cpu_clk);
            #1;
            if (i < comp && rf_we_wb !== 1'b0) bubble_ok = 1'b0;
         end
         if (timed_out) err_exp = 1'b1;
         check($sformatf("rnd%0d_req", t), req_ok, 1'b1);
         check($sformatf("rnd%0d_stall", t), n_stall, comp);
         check($sformatf("rnd%0d_bubble", t), bubble_ok, 1'b1);
         check($sformatf("rnd%0d_wd_wb", t), wd_wb, exp_fwd);
         check($sformatf("rnd%0d_wr_wb", t), wr_wb, wr);
         check($sformatf("rnd%0d_rf_we_wb", t), rf_we_wb, rf_we && (wr != 5'd0));
         check($sformatf("rnd%0d_err", t), bus_err, err_exp);
         bus_if.bus_ack = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
